// File: rtl/uart_rx_pkg.sv
// Shared UART definitions: 3-bit state encodings, default clock/baud, bit-period rounding.
// Used by both the receiver and the transmitter.
package uart_rx_pkg;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_START  = 3'd1;
  localparam logic [2:0] ST_DATA   = 3'd2;
  localparam logic [2:0] ST_PARITY = 3'd3;
  localparam logic [2:0] ST_STOP   = 3'd4;
  localparam logic [2:0] ST_BREAK  = 3'd5;

  localparam int DEFAULT_CLK_HZ = 25000000;
  localparam int DEFAULT_BAUD   = 115200;

  // Clock cycles per bit, rounded to the nearest integer.
  function automatic int clks_per_bit(input int clk_hz, input int baud);
    return (clk_hz + baud / 2) / baud;
  endfunction

endpackage

// File: rtl/uart_rx_sync2.sv
// Two-flop synchroniser for an asynchronous pin; RESET_VAL sets the idle level
// that both flops take while reset is asserted.
module uart_sync2 #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic r_meta;
  logic r_sync;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_meta <= RESET_VAL;
      r_sync <= RESET_VAL;
    end else begin
      r_meta <= d;
      r_sync <= r_meta;
    end
  end

  assign q = r_sync;

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver, LSB first, mid-bit sampling, valid/ready holding register.
// Define UART_RX_PARITY_EN to expect an even-parity bit after bit 7.
module uart_rx
  import uart_rx_pkg::*;
#(
  parameter int CLK_HZ = DEFAULT_CLK_HZ,
  parameter int BAUD   = DEFAULT_BAUD
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic       frame_err,
  output logic       overrun,
  output logic       busy
);

  localparam int CPB = clks_per_bit(CLK_HZ, BAUD);
  localparam int CW  = $clog2(CPB);
  localparam logic [CW-1:0] HALF_M1 = CW'(CPB / 2 - 1);
  localparam logic [CW-1:0] FULL_M1 = CW'(CPB - 1);

  logic          w_rx_s;
  logic          w_expire;
  logic          w_done;
  logic          w_take;
  logic [2:0]    r_state;
  logic [CW-1:0] r_cnt;
  logic [2:0]    r_idx;
  logic [7:0]    r_shift;
  logic          r_par_err;
  logic [7:0]    r_data;
  logic          r_valid;
  logic          r_frame_err;
  logic          r_overrun;

  uart_sync2 #(.RESET_VAL(1'b1)) u_sync (
    .clk   (clk),
    .reset (reset),
    .d     (rx),
    .q     (w_rx_s)
  );

  assign w_expire = (r_cnt == '0);
  assign w_done   = (r_state == ST_STOP) && w_expire && w_rx_s && !r_par_err;
  assign w_take   = r_valid && rx_ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= ST_IDLE;
      r_cnt       <= '0;
      r_idx       <= 3'd0;
      r_shift     <= 8'h00;
      r_par_err   <= 1'b0;
      r_frame_err <= 1'b0;
    end else begin
      r_frame_err <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (!w_rx_s) begin
            r_cnt   <= HALF_M1;
            r_state <= ST_START;
          end
        end
        ST_START: begin
          if (!w_expire) begin
            r_cnt <= r_cnt - 1'b1;
          end else if (w_rx_s) begin
            r_state <= ST_IDLE;
          end else begin
            r_cnt     <= FULL_M1;
            r_idx     <= 3'd0;
            r_par_err <= 1'b0;
            r_state   <= ST_DATA;
          end
        end
        ST_DATA: begin
          if (!w_expire) begin
            r_cnt <= r_cnt - 1'b1;
          end else begin
            r_shift[r_idx] <= w_rx_s;
            r_cnt          <= FULL_M1;
            if (r_idx == 3'd7) begin
`ifdef UART_RX_PARITY_EN
              r_state <= ST_PARITY;
`else
              r_state <= ST_STOP;
`endif
            end else begin
              r_idx <= r_idx + 3'd1;
            end
          end
        end
`ifdef UART_RX_PARITY_EN
        ST_PARITY: begin
          if (!w_expire) begin
            r_cnt <= r_cnt - 1'b1;
          end else begin
            // Even parity: data plus parity bit must hold an even count of ones.
            r_par_err <= (^r_shift) ^ w_rx_s;
            r_cnt     <= FULL_M1;
            r_state   <= ST_STOP;
          end
        end
`endif
        ST_STOP: begin
          if (!w_expire) begin
            r_cnt <= r_cnt - 1'b1;
          end else if (!w_rx_s) begin
            r_frame_err <= 1'b1;
            r_state     <= ST_BREAK;
          end else begin
            r_frame_err <= r_par_err;
            r_state     <= ST_IDLE;
          end
        end
        ST_BREAK: begin
          // Only a returning high line re-arms; a held-low line must not restart a frame.
          if (w_rx_s) r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_data    <= 8'h00;
      r_valid   <= 1'b0;
      r_overrun <= 1'b0;
    end else begin
      r_overrun <= 1'b0;
      if (w_done) begin
        if (!r_valid || w_take) begin
          r_data  <= r_shift;
          r_valid <= 1'b1;
        end else begin
          r_overrun <= 1'b1;
        end
      end else if (w_take) begin
        r_valid <= 1'b0;
      end
    end
  end

  assign rx_data   = r_data;
  assign rx_valid  = r_valid;
  assign frame_err = r_frame_err;
  assign overrun   = r_overrun;
  assign busy      = (r_state != ST_IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: expected bytes/error pulses queued by the stimulus,
// popped and compared by an independent monitor; plus direct status checks.
module tb_uart_rx;

  localparam int CPB = 217;
`ifdef UART_RX_PARITY_EN
  localparam int PAR = 1;
`else
  localparam int PAR = 0;
`endif
  // Edge offset (from the pin's falling edge) at which the stop bit is sampled.
  localparam int STOP_EDGE = 2064 + PAR * CPB;

  localparam int EV_BYTE = 0;
  localparam int EV_FERR = 1;
  localparam int EV_OVR  = 2;

  typedef struct {
    int         kind;
    logic [7:0] data;
  } ev_t;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       rx = 1'b1;
  logic       rx_ready = 1'b1;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       frame_err;
  logic       overrun;
  logic       busy;

  int  n_checks = 0;
  int  n_errors = 0;
  int  cyc = 0;
  int  t_fall = 0;
  int  t_hs = 0;
  ev_t exp_q[$];

  uart_rx dut (
    .clk       (clk),
    .reset     (reset),
    .rx        (rx),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .rx_ready  (rx_ready),
    .frame_err (frame_err),
    .overrun   (overrun),
    .busy      (busy)
  );

  always #20 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
    end else begin
      $display("ok   %s: %0d (0x%0h)", name, act, act);
    end
  endtask

  task automatic push(input int kind, input logic [7:0] data);
    ev_t e;
    e.kind = kind;
    e.data = data;
    exp_q.push_back(e);
  endtask

  task automatic observe(input int kind, input logic [7:0] data);
    ev_t e;
    n_checks++;
    if (exp_q.size() == 0) begin
      n_errors++;
      $display("FAIL unexpected_event: got kind %0d data 0x%02h at cycle %0d, expected none", kind, data, cyc);
    end else begin
      e = exp_q.pop_front();
      if (e.kind != kind || (kind == EV_BYTE && e.data !== data)) begin
        n_errors++;
        $display("FAIL event: got kind %0d data 0x%02h at cycle %0d, expected kind %0d data 0x%02h",
                 kind, data, cyc, e.kind, e.data);
      end else begin
        $display("ok   event: kind %0d data 0x%02h at cycle %0d", kind, data, cyc);
      end
    end
  endtask

  // Monitor: byte handshakes and error pulses, sampled mid-cycle.
  always @(negedge clk) begin
    if (!reset) begin
      if (rx_valid && rx_ready) begin
        t_hs = cyc;
        observe(EV_BYTE, rx_data);
      end
      if (frame_err) observe(EV_FERR, 8'h00);
      if (overrun)   observe(EV_OVR, 8'h00);
    end
  end

  initial begin
    #(40 * 100000);
    $display("FAIL watchdog: simulation exceeded 100000 cycles");
    $fatal(1, "watchdog");
  end

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // One full frame; with stop_v = 0 the line is left low afterwards.
  task automatic send_frame(input logic [7:0] d, input logic stop_v);
    @(posedge clk);
    #1;
    rx = 1'b0;
    t_fall = cyc;
    wait_cycles(CPB);
    for (int i = 0; i < 8; i++) begin
      rx = d[i];
      wait_cycles(CPB);
    end
    if (PAR != 0) begin
      rx = ^d;
      wait_cycles(CPB);
    end
    rx = stop_v;
    wait_cycles(CPB);
    if (stop_v) rx = 1'b1;
  endtask

  task automatic pulse_ready();
    @(posedge clk);
    #1;
    rx_ready = 1'b1;
    @(posedge clk);
    #1;
    rx_ready = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_rx_data"}, rx_data, 8'h00);
    check({tag, "_rx_valid"}, rx_valid, 0);
    check({tag, "_frame_err"}, frame_err, 0);
    check({tag, "_overrun"}, overrun, 0);
    check({tag, "_busy"}, busy, 0);
  endtask

  initial begin
    wait_cycles(3);
    check_reset_outputs("reset");
    reset = 1'b0;
    wait_cycles(10);

    // 1: A5 with ready held high, latency from pin fall.
    push(EV_BYTE, 8'hA5);
    send_frame(8'hA5, 1'b1);
    check("a5_latency_ok", ((t_hs - t_fall) >= 2063 + PAR * CPB && (t_hs - t_fall) <= 2065 + PAR * CPB) ? 1 : 0, 1);
    check("a5_valid_one_cycle", rx_valid, 0);
    wait_cycles(20);

    // 2: 50-cycle glitch is a false start.
    rx = 1'b0;
    wait_cycles(20);
    check("glitch_busy_high", busy, 1);
    wait_cycles(30);
    rx = 1'b1;
    wait_cycles(70);
    check("glitch_busy_low", busy, 0);
    check("glitch_no_valid", rx_valid, 0);
    push(EV_BYTE, 8'h3C);
    send_frame(8'h3C, 1'b1);
    wait_cycles(20);

    // 3: stop bit low then a long break.
    push(EV_FERR, 8'h00);
    send_frame(8'h81, 1'b0);
    wait_cycles(5000 - CPB);
    check("break_busy", busy, 1);
    check("break_no_valid", rx_valid, 0);
    rx = 1'b1;
    wait_cycles(5);
    check("break_released", busy, 0);
    push(EV_BYTE, 8'h55);
    send_frame(8'h55, 1'b1);
    wait_cycles(20);

    // 4: overrun with the consumer stalled.
    rx_ready = 1'b0;
    push(EV_OVR, 8'h00);
    push(EV_BYTE, 8'h11);
    send_frame(8'h11, 1'b1);
    send_frame(8'h22, 1'b1);
    wait_cycles(10);
    check("ovr_valid_held", rx_valid, 1);
    check("ovr_data_held", rx_data, 8'h11);
    pulse_ready();
    check("ovr_valid_cleared", rx_valid, 0);
    wait_cycles(10);

    // 5: handshake exactly on the completion edge of the next byte.
    push(EV_BYTE, 8'h33);
    push(EV_BYTE, 8'h22);
    send_frame(8'h33, 1'b1);
    wait_cycles(10);
    fork
      send_frame(8'h22, 1'b1);
      begin
        @(posedge clk);
        wait_cycles(STOP_EDGE - 1);
        rx_ready = 1'b1;
        wait_cycles(1);
        rx_ready = 1'b0;
      end
    join
    check("simul_valid", rx_valid, 1);
    check("simul_data", rx_data, 8'h22);
    pulse_ready();
    check("simul_drained", rx_valid, 0);
    rx_ready = 1'b1;
    wait_cycles(10);

    // 6: reset during bit 4 of FF, then 0F.
    fork
      send_frame(8'hFF, 1'b1);
      begin
        @(posedge clk);
        wait_cycles(5 * CPB + 100);
        check("pre_reset_busy", busy, 1);
        reset = 1'b1;
        #1;
        check_reset_outputs("midframe_reset");
        wait_cycles(3);
        check_reset_outputs("held_reset");
        reset = 1'b0;
      end
    join
    wait_cycles(20);
    check("after_reset_no_valid", rx_valid, 0);
    push(EV_BYTE, 8'h0F);
    send_frame(8'h0F, 1'b1);
    wait_cycles(20);

    check("queue_drained", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
